// File: rtl/regf_mp_if.sv
// Register file bundle: read ports, writeback, issue allocation and flush.
// Master drives requests; slave returns read data, busy flags and scoreboard.
interface regf_mp_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRP  = 2
);
    localparam int AW = $clog2(NREG);

    logic [NRP-1:0]      rd_en;
    logic [NRP*AW-1:0]   rd_addr;
    logic [NRP*XLEN-1:0] rd_data;
    logic [NRP-1:0]      rd_busy;
    logic                w_enable;
    logic [AW-1:0]       w_addr;
    logic [XLEN-1:0]     w_data;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    logic                flush;
    logic [NREG-1:0]     busy_vec;

    modport master (
        output rd_en, rd_addr, w_enable, w_addr, w_data,
        output alloc_en, alloc_addr, flush,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_en, rd_addr, w_enable, w_addr, w_data,
        input  alloc_en, alloc_addr, flush,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/regf_mp.sv
// Multi-read-port integer register file with registered reads,
// optional write-first bypass and a per-register busy scoreboard.
module regf_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRP      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic       clk,
    input logic       rstn,
    regf_mp_if.slave  bus
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            wr_en;
    logic [AW-1:0]   raddr  [NRP];
    logic [XLEN-1:0] d_nxt  [NRP];
    logic [XLEN-1:0] d_q    [NRP];
    logic [NRP-1:0]  b_q;

    assign wr_en = bus.w_enable &&
                   !(ZERO_REG != 0 && bus.w_addr == '0);

    // Flush wins; a same-cycle alloc outranks the writeback clear.
    always_comb begin
        busy_nxt = busy;
        if (bus.flush) begin
            busy_nxt = '0;
        end else begin
            if (bus.w_enable)
                busy_nxt[bus.w_addr] = 1'b0;
            if (bus.alloc_en)
                busy_nxt[bus.alloc_addr] = 1'b1;
        end
        if (ZERO_REG != 0)
            busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            busy <= '0;
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else begin
            busy <= busy_nxt;
            if (wr_en)
                regs[bus.w_addr] <= bus.w_data;
        end
    end

    always_comb begin
        for (int k = 0; k < NRP; k++) begin
            raddr[k] = bus.rd_addr[k*AW +: AW];
            d_nxt[k] = regs[raddr[k]];
            if (BYPASS != 0 && wr_en && bus.w_addr == raddr[k])
                d_nxt[k] = bus.w_data;
            if (ZERO_REG != 0 && raddr[k] == '0)
                d_nxt[k] = '0;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            b_q <= '0;
            for (int k = 0; k < NRP; k++)
                d_q[k] <= '0;
        end else begin
            for (int k = 0; k < NRP; k++) begin
                if (bus.rd_en[k]) begin
                    d_q[k] <= d_nxt[k];
                    b_q[k] <= busy_nxt[raddr[k]];
                end
            end
        end
    end

    always_comb begin
        bus.rd_data = '0;
        for (int k = 0; k < NRP; k++)
            bus.rd_data[k*XLEN +: XLEN] = d_q[k];
    end

    assign bus.rd_busy  = b_q;
    assign bus.busy_vec = busy;
endmodule

// File: tb/tb_regf_mp.sv
// Bench for regf_mp: bypass and read-old instances share stimulus
// and are compared against an array-based reference model.
module tb_regf_mp;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRP  = 2;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    regf_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) b1 ();
    regf_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) b0 ();

    regf_mp #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP),
              .ZERO_REG(1), .BYPASS(1)) dut1 (
        .clk(clk), .rstn(rstn), .bus(b1.slave));
    regf_mp #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP),
              .ZERO_REG(1), .BYPASS(0)) dut0 (
        .clk(clk), .rstn(rstn), .bus(b0.slave));

    logic [NRP-1:0]    rd_en;
    logic [NRP*AW-1:0] rd_addr;
    logic              w_enable;
    logic [AW-1:0]     w_addr;
    logic [XLEN-1:0]   w_data;
    logic              alloc_en;
    logic [AW-1:0]     alloc_addr;
    logic              flush;

    assign b1.rd_en = rd_en;       assign b0.rd_en = rd_en;
    assign b1.rd_addr = rd_addr;   assign b0.rd_addr = rd_addr;
    assign b1.w_enable = w_enable; assign b0.w_enable = w_enable;
    assign b1.w_addr = w_addr;     assign b0.w_addr = w_addr;
    assign b1.w_data = w_data;     assign b0.w_data = w_data;
    assign b1.alloc_en = alloc_en; assign b0.alloc_en = alloc_en;
    assign b1.alloc_addr = alloc_addr;
    assign b0.alloc_addr = alloc_addr;
    assign b1.flush = flush;       assign b0.flush = flush;

    int n_tests = 0;
    int n_fail  = 0;

    logic [XLEN-1:0] m_regs [NREG];
    logic [NREG-1:0] m_busy;
    logic [XLEN-1:0] exp_d1 [NRP];
    logic [XLEN-1:0] exp_d0 [NRP];
    logic            exp_b  [NRP];

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = '0;
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        for (int k = 0; k < NRP; k++) begin
            exp_d1[k] = '0;
            exp_d0[k] = '0;
            exp_b[k]  = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < NRP; k++) begin
            check($sformatf("%s byp_data%0d", tag, k),
                  64'(b1.rd_data[k*XLEN +: XLEN]), 64'(exp_d1[k]));
            check($sformatf("%s old_data%0d", tag, k),
                  64'(b0.rd_data[k*XLEN +: XLEN]), 64'(exp_d0[k]));
            check($sformatf("%s byp_busy%0d", tag, k),
                  64'(b1.rd_busy[k]), 64'(exp_b[k]));
            check($sformatf("%s old_busy%0d", tag, k),
                  64'(b0.rd_busy[k]), 64'(exp_b[k]));
        end
        check({tag, " byp_vec"}, 64'(b1.busy_vec), 64'(m_busy));
        check({tag, " old_vec"}, 64'(b0.busy_vec), 64'(m_busy));
    endtask

    task automatic drive(input logic [1:0] re, input int a0, input int a1,
                         input logic we, input int wa, input logic [31:0] wd,
                         input logic al, input int aa, input logic fl);
        rd_en      = re;
        rd_addr    = {AW'(a1), AW'(a0)};
        w_enable   = we;
        w_addr     = AW'(wa);
        w_data     = wd;
        alloc_en   = al;
        alloc_addr = AW'(aa);
        flush      = fl;
    endtask

    // Apply one clock of the current inputs to the model, then check.
    task automatic step(input string tag);
        int a [NRP];
        for (int k = 0; k < NRP; k++) begin
            a[k] = int'(rd_addr[k*AW +: AW]);
            if (rd_en[k]) begin
                exp_d0[k] = (a[k] == 0) ? '0 : m_regs[a[k]];
                exp_d1[k] = exp_d0[k];
                if (w_enable && a[k] != 0 && int'(w_addr) == a[k])
                    exp_d1[k] = w_data;
            end
        end
        if (w_enable && w_addr != 0) m_regs[w_addr] = w_data;
        if (flush) m_busy = '0;
        else begin
            if (w_enable) m_busy[w_addr] = 1'b0;
            if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
        end
        for (int k = 0; k < NRP; k++)
            if (rd_en[k]) exp_b[k] = m_busy[a[k]];
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    function automatic int raddr();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                           : int'($urandom_range(0, 7));
    endfunction

    initial begin
        rstn = 1'b1;
        drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rstn = 1'b0;

        drive(2'b00, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        step("wr5");
        drive(2'b11, 5, 5, 0, 0, 0, 0, 0, 0);
        step("rd5");

        drive(2'b11, 7, 7, 1, 7, 32'h12345678, 0, 0, 0);
        step("bypass7");

        drive(2'b11, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 0);
        step("zero");

        drive(2'b00, 0, 0, 0, 0, 0, 1, 3, 0);
        step("alloc3");
        drive(2'b01, 3, 0, 0, 0, 0, 0, 0, 0);
        step("rd3busy");
        drive(2'b11, 3, 3, 1, 3, 32'h33, 1, 3, 0);
        step("wb_alloc3");
        drive(2'b10, 0, 3, 1, 3, 32'h44, 0, 0, 0);
        step("wb3");

        drive(2'b00, 0, 0, 0, 0, 0, 1, 1, 0);
        step("alloc1");
        drive(2'b00, 0, 0, 0, 0, 0, 1, 2, 0);
        step("alloc2");
        drive(2'b00, 0, 0, 0, 0, 0, 1, 4, 0);
        step("alloc4");
        drive(2'b11, 2, 4, 1, 9, 32'hA5, 1, 6, 1);
        step("flush");
        drive(2'b11, 9, 1, 0, 0, 0, 0, 0, 0);
        step("rd9");
        drive(2'b00, 4, 7, 0, 0, 0, 1, 10, 0);
        step("hold_a");
        drive(2'b00, 3, 6, 1, 10, 32'h10, 0, 0, 0);
        step("hold_b");

        for (int i = 0; i < 400; i++) begin
            drive(2'($urandom_range(0, 3)), raddr(), raddr(),
                  1'($urandom_range(0, 1)), raddr(), $urandom(),
                  1'($urandom_range(0, 1)), raddr(),
                  1'($urandom_range(0, 19) == 0));
            step("rand");
        end

        drive(2'b00, 0, 0, 0, 0, 0, 1, 12, 0);
        step("pre_rst");
        #2;
        rstn = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rstn = 1'b0;
        for (int r = 0; r < NREG; r += 2) begin
            drive(2'b11, r, r + 1, 0, 0, 0, 0, 0, 0);
            step("post_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/regf_mp.md
Name: regf_mp

Overview:
Parametrised multi-read-port register file with synchronous registered reads, write-first bypass and a per-register busy scoreboard. It is the next generation of the core's integer register file and serves the same purpose: decode reads operands, writeback writes results. Issue marks the destination register busy, and writeback clears it, so the pipeline can detect RAW hazards on operands that are still in flight. A flush clears all in-flight state.

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers (power of two, >=2)
NRP, 2, number of read ports
ZERO_REG, 1, 1 = register 0 is hardwired to zero and is never busy
BYPASS, 1, 1 = same-cycle writeback is forwarded to reads (write-first); 0 = read-old
AW, $clog2(NREG), address width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous reset, active-high (1 = reset asserted)
rd_en  in  NRP  per-port read enable
rd_addr  in  NRP*AW  read addresses; port k uses bits [k*AW +: AW]
rd_data  out  NRP*XLEN  registered read data, port k at [k*XLEN +: XLEN]
rd_busy  out  NRP  registered busy flag of the register read on port k
w_enable  in  1  writeback valid
w_addr  in  AW  writeback register
w_data  in  XLEN  writeback data
alloc_en  in  1  issue: mark alloc_addr busy
alloc_addr  in  AW  destination register being issued
flush  in  1  synchronous: clear all busy bits
busy_vec  out  NREG  current scoreboard state, for debug and stall logic

Behaviour:
- Reset (rstn=1, asynchronous): all registers = 0, all busy bits = 0, rd_data = 0, rd_busy = 0. Reset dominates every other input. Normal operation resumes on the first clk edge after rstn falls.
- Read latency is 1 cycle. When rd_en[k]=1 at edge N, rd_data[k] and rd_busy[k] hold the result from edge N until the next enabled read on that port.
- When rd_en[k]=0, rd_data[k] and rd_busy[k] hold their previous values.
- Write: when w_enable=1, regs[w_addr] <= w_data at the edge.
- With ZERO_REG=1, a write to address 0 is dropped, and reads of address 0 return 0 with busy = 0.
- Bypass, BYPASS=1: if w_enable=1 and w_addr==rd_addr[k] (and the address is not the zero register) in the same cycle, rd_data[k] = w_data.
- Bypass, BYPASS=0: under the same conditions, rd_data[k] = the old register contents.
- Scoreboard update at each edge, applied in priority order:
  1. flush=1: all busy bits cleared; alloc_en and the busy-clear from w_enable are ignored. The data write still occurs.
  2. Otherwise, w_enable=1 clears busy[w_addr].
  3. Then alloc_en=1 sets busy[alloc_addr]. If alloc_addr == w_addr in the same cycle, the register ends busy, because a new producer owns it.
  4. alloc to the zero register (ZERO_REG=1) is ignored.
- rd_busy[k] reports the busy bit after the update of the same edge. Examples:
  - Read and writeback to the same address: rd_busy = 0.
  - Read and alloc to the same address: rd_busy = 1.
  - Read during flush: rd_busy = 0.
- busy_vec is registered state and reflects all updates made at the most recent edge.
- Multiple read ports may use the same address. Each port behaves identically and independently.
- Addresses >= NREG cannot occur (NREG is a power of two).

Test Plan:
- Reset: set rstn=1 mid-run after registers were written -> asynchronously rd_data=0, busy_vec=0. After release, a read of any register returns 0.
- Basic write/read: w_enable, w_addr=5, w_data=0xDEADBEEF; next cycle rd_en=2'b11, rd_addr={5,5} -> one cycle later both ports read 0xDEADBEEF with rd_busy=0.
- Bypass (BYPASS=1): write reg 7 = 0x12345678 while reading reg 7 in the same cycle -> rd_data=0x12345678 next cycle. Repeat with BYPASS=0 -> rd_data equals the prior value, 0.
- Zero register: write x0 = 0xFFFFFFFF and alloc x0 -> the x0 read returns 0, busy_vec[0]=0.
- Scoreboard: alloc r3 -> busy_vec[3]=1 and a read of r3 gives rd_busy=1. Then writeback r3 together with alloc r3 in the same cycle -> busy_vec[3] stays 1. Then writeback r3 alone -> busy_vec[3]=0.
- Flush: alloc r1, r2, r4, then flush together with alloc r6 and w_enable to r9 = 0xA5 -> busy_vec=0 and r9 reads 0xA5. Also set rd_en=0 with changing rd_addr -> rd_data/rd_busy hold their previous values.
